// File: rtl/core_bus_arbiter_pkg.sv
// Shared core bus types: Avalon-MM command/response structs plus the
// arbiter's FSM state and owner encodings.
package core_bus_arbiter_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;
  } avalon_resp_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCK    = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IBUS = 2'd1,
    OWN_DBUS = 2'd2
  } owner_t;

endpackage

// File: rtl/core_bus_arbiter.sv
// Two-master (ibus/dbus) to one-slave Avalon-MM arbiter with zero-latency
// grant in IDLE, grant locking on waitrequest and a single outstanding read.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned RR_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  ibus_avalon_req,
  output avalon_resp_t ibus_avalon_resp,
  input  avalon_req_t  dbus_avalon_req,
  output avalon_resp_t dbus_avalon_resp,
  output avalon_req_t  mem_avalon_req,
  input  avalon_resp_t mem_avalon_resp
);

  arb_state_t state;
  owner_t     owner;
  owner_t     last_grant;
  owner_t     grant;
  logic       ibus_act;
  logic       dbus_act;
  logic       rd_done;

  always_comb begin
    ibus_act = ibus_avalon_req.read | ibus_avalon_req.write;
    dbus_act = dbus_avalon_req.read | dbus_avalon_req.write;
    grant    = OWN_NONE;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (ibus_act && dbus_act)
            grant = ((RR_EN != 0) && (last_grant == OWN_DBUS)) ? OWN_IBUS : OWN_DBUS;
          else if (ibus_act)
            grant = OWN_IBUS;
          else if (dbus_act)
            grant = OWN_DBUS;
        end
        // A stalled command keeps its grant; the other master is never considered.
        LOCK: begin
          if (owner == OWN_IBUS && ibus_act)
            grant = OWN_IBUS;
          else if (owner == OWN_DBUS && dbus_act)
            grant = OWN_DBUS;
        end
        default: grant = OWN_NONE;
      endcase
    end
  end

  always_comb begin
    mem_avalon_req                 = '0;
    rd_done                        = !rst && (state == RD_WAIT) && mem_avalon_resp.readdatavalid;
    ibus_avalon_resp.readdata      = mem_avalon_resp.readdata;
    dbus_avalon_resp.readdata      = mem_avalon_resp.readdata;
    ibus_avalon_resp.waitrequest   = 1'b1;
    dbus_avalon_resp.waitrequest   = 1'b1;
    ibus_avalon_resp.readdatavalid = rd_done && (owner == OWN_IBUS);
    dbus_avalon_resp.readdatavalid = rd_done && (owner == OWN_DBUS);
    if (grant == OWN_IBUS) begin
      mem_avalon_req               = ibus_avalon_req;
      ibus_avalon_resp.waitrequest = mem_avalon_resp.waitrequest;
    end else if (grant == OWN_DBUS) begin
      mem_avalon_req               = dbus_avalon_req;
      dbus_avalon_resp.waitrequest = mem_avalon_resp.waitrequest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      last_grant <= OWN_DBUS;
    end else begin
      case (state)
        IDLE, LOCK: begin
          if (grant == OWN_NONE) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end else if (mem_avalon_resp.waitrequest) begin
            state <= LOCK;
            owner <= grant;
          end else begin
            last_grant <= grant;
            if (mem_avalon_req.read) begin
              state <= RD_WAIT;
              owner <= grant;
            end else begin
              state <= IDLE;
              owner <= OWN_NONE;
            end
          end
        end
        RD_WAIT: begin
          if (mem_avalon_resp.readdatavalid) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the ibus/dbus arbiter (round-robin instance and a fixed-priority instance).
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  logic         clk;
  logic         rst;
  avalon_req_t  ibus_req, dbus_req;
  avalon_resp_t mem_resp;
  avalon_resp_t ibus_resp, dbus_resp, fp_ibus_resp, fp_dbus_resp;
  avalon_req_t  mem_req, fp_mem_req;

  int n_checks = 0;
  int n_fail   = 0;

  core_bus_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .rst(rst),
    .ibus_avalon_req(ibus_req), .ibus_avalon_resp(ibus_resp),
    .dbus_avalon_req(dbus_req), .dbus_avalon_resp(dbus_resp),
    .mem_avalon_req(mem_req), .mem_avalon_resp(mem_resp)
  );

  core_bus_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .ibus_avalon_req(ibus_req), .ibus_avalon_resp(fp_ibus_resp),
    .dbus_avalon_req(dbus_req), .dbus_avalon_resp(fp_dbus_resp),
    .mem_avalon_req(fp_mem_req), .mem_avalon_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven 2 time units after the edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic avalon_req_t mk(input logic rd, input logic wr,
                                     input logic [31:0] addr, input logic [31:0] data);
    avalon_req_t r;
    r.read        = rd;
    r.write       = wr;
    r.address     = addr;
    r.writedata   = data;
    r.byte_enable = 4'hF;
    return r;
  endfunction

  function automatic avalon_req_t rand_cmd();
    int k;
    k = $urandom_range(0, 3);
    return mk(k == 2, k == 3, $urandom, $urandom);
  endfunction

  // Model state: master holding an outstanding read, master stalled on
  // waitrequest, and the master granted most recently (0 none, 1 ibus, 2 dbus).
  int m_out, m_stall, m_last, g, rd_cnt;
  logic exp_ib_wait, exp_db_wait, exp_ib_rdv, exp_db_rdv, i_act, d_act;
  avalon_req_t gc, ib_next, db_next;

  initial begin
    rst = 1'b1; ibus_req = '0; dbus_req = '0; mem_resp = '0;

    // Reset outputs, with a request and a stray readdatavalid present.
    step();
    ibus_req = mk(1, 0, 32'h100, 0);
    mem_resp.readdatavalid = 1'b1;
    #1;
    check("rst_mem_read", mem_req.read, 0);
    check("rst_ibus_wait", ibus_resp.waitrequest, 1);
    check("rst_dbus_wait", dbus_resp.waitrequest, 1);
    check("rst_ibus_rdv", ibus_resp.readdatavalid, 0);

    // Test 1: ibus read 0x100, data returned two cycles later.
    step(); rst = 1'b0; mem_resp.readdatavalid = 1'b0; #1;
    check("t1_mem_read", mem_req.read, 1);
    check("t1_mem_addr", mem_req.address, 32'h100);
    check("t1_ibus_wait", ibus_resp.waitrequest, 0);
    check("t1_dbus_wait", dbus_resp.waitrequest, 1);
    step(); ibus_req = '0; #1;
    check("t1_rdwait_mem_read", mem_req.read, 0);
    step(); mem_resp.readdatavalid = 1'b1; mem_resp.readdata = 32'hDEADBEEF; #1;
    check("t1_ibus_rdv", ibus_resp.readdatavalid, 1);
    check("t1_ibus_data", ibus_resp.readdata, 32'hDEADBEEF);
    check("t1_dbus_rdv", dbus_resp.readdatavalid, 0);
    step(); mem_resp.readdatavalid = 1'b0;

    // Test 2: simultaneous reads after reset, round-robin.
    rst = 1'b1; step(); rst = 1'b0;
    ibus_req = mk(1, 0, 32'h104, 0); dbus_req = mk(1, 0, 32'h208, 0); #1;
    check("t2_first_addr", mem_req.address, 32'h104);
    check("t2_first_ibus_wait", ibus_resp.waitrequest, 0);
    check("t2_first_dbus_wait", dbus_resp.waitrequest, 1);
    step(); ibus_req = '0; #1;
    check("t2_rdwait_dbus_wait", dbus_resp.waitrequest, 1);
    step(); mem_resp.readdatavalid = 1'b1; mem_resp.readdata = 32'h1111; #1;
    check("t2_ibus_rdv", ibus_resp.readdatavalid, 1);
    check("t2_dbus_rdv_blocked", dbus_resp.readdatavalid, 0);
    step(); mem_resp.readdatavalid = 1'b0; #1;
    check("t2_second_addr", mem_req.address, 32'h208);
    check("t2_second_dbus_wait", dbus_resp.waitrequest, 0);
    step(); dbus_req = '0;
    step(); mem_resp.readdatavalid = 1'b1; mem_resp.readdata = 32'h2222; #1;
    check("t2_dbus_rdv", dbus_resp.readdatavalid, 1);
    check("t2_ibus_rdv_none", ibus_resp.readdatavalid, 0);
    step(); mem_resp.readdatavalid = 1'b0;
    ibus_req = mk(1, 0, 32'h10C, 0); dbus_req = mk(1, 0, 32'h20C, 0); #1;
    check("t2_next_tie_addr", mem_req.address, 32'h10C);
    step(); ibus_req = '0; dbus_req = '0;
    step(); mem_resp.readdatavalid = 1'b1;
    step(); mem_resp.readdatavalid = 1'b0;

    // Test 3: dbus write stalled 3 cycles; ibus arrives mid-stall.
    rst = 1'b1; step(); rst = 1'b0;
    dbus_req = mk(0, 1, 32'h200, 32'h12345678); mem_resp.waitrequest = 1'b1; #1;
    check("t3_c0_cmd", mem_req, dbus_req);
    check("t3_c0_dbus_wait", dbus_resp.waitrequest, 1);
    step(); ibus_req = mk(1, 0, 32'h110, 0); #1;
    check("t3_c1_cmd", mem_req, mk(0, 1, 32'h200, 32'h12345678));
    check("t3_c1_ibus_wait", ibus_resp.waitrequest, 1);
    step(); #1;
    check("t3_c2_cmd", mem_req, mk(0, 1, 32'h200, 32'h12345678));
    step(); mem_resp.waitrequest = 1'b0; #1;
    check("t3_c3_cmd", mem_req, mk(0, 1, 32'h200, 32'h12345678));
    check("t3_c3_dbus_wait", dbus_resp.waitrequest, 0);
    check("t3_c3_ibus_wait", ibus_resp.waitrequest, 1);
    step(); dbus_req = '0; #1;
    check("t3_ibus_after_addr", mem_req.address, 32'h110);
    check("t3_ibus_after_wait", ibus_resp.waitrequest, 0);
    step(); ibus_req = '0;
    step(); mem_resp.readdatavalid = 1'b1;
    step(); mem_resp.readdatavalid = 1'b0;

    // Test 5: reset during RD_WAIT, then a stray readdatavalid.
    ibus_req = mk(1, 0, 32'h120, 0);
    step(); ibus_req = '0; rst = 1'b1;
    step(); rst = 1'b0; mem_resp.readdatavalid = 1'b1;
    dbus_req = mk(0, 1, 32'h300, 32'hABCD); #1;
    check("t5_ibus_rdv", ibus_resp.readdatavalid, 0);
    check("t5_dbus_rdv", dbus_resp.readdatavalid, 0);
    check("t5_idle_write", mem_req.write, 1);
    check("t5_idle_dbus_wait", dbus_resp.waitrequest, 0);

    // Test 6: dbus write then ibus read back to back.
    step(); mem_resp.readdatavalid = 1'b0; dbus_req = mk(0, 1, 32'h304, 32'h55); #1;
    check("t6_write", mem_req, dbus_req);
    check("t6_write_wait", dbus_resp.waitrequest, 0);
    step(); dbus_req = '0; ibus_req = mk(1, 0, 32'h130, 0); #1;
    check("t6_read", mem_req, ibus_req);
    check("t6_read_wait", ibus_resp.waitrequest, 0);
    step(); ibus_req = '0;
    step(); mem_resp.readdatavalid = 1'b1;
    step(); mem_resp.readdatavalid = 1'b0;

    // Test 4: continuous writes on both masters; fixed priority vs round-robin.
    rst = 1'b1; step(); rst = 1'b0;
    ibus_req = mk(0, 1, 32'h140, 1); dbus_req = mk(0, 1, 32'h240, 2);
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t4_fp_addr", fp_mem_req.address, 32'h240);
      check("t4_fp_ibus_wait", fp_ibus_resp.waitrequest, 1);
      check("t4_fp_dbus_wait", fp_dbus_resp.waitrequest, 0);
      check("t4_rr_addr", mem_req.address, (k % 2 == 0) ? 32'h140 : 32'h240);
      step();
    end

    // Randomized run against the transaction-level model.
    rst = 1'b1; ibus_req = '0; dbus_req = '0; mem_resp = '0;
    step(); rst = 1'b0;
    m_out = 0; m_stall = 0; m_last = 2; rd_cnt = 0;
    ib_next = rand_cmd(); db_next = rand_cmd();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 79) == 0);
      mem_resp.waitrequest   = ($urandom_range(0, 2) == 0);
      mem_resp.readdata      = $urandom;
      mem_resp.readdatavalid = (rd_cnt == 1) || (rd_cnt == 0 && $urandom_range(0, 15) == 0);
      if (rd_cnt > 0) rd_cnt--;
      ibus_req = ib_next;
      dbus_req = db_next;
      #1;
      i_act = ibus_req.read | ibus_req.write;
      d_act = dbus_req.read | dbus_req.write;
      g = 0;
      if (!rst && m_out == 0) begin
        if (m_stall != 0) g = m_stall;
        else if (i_act && d_act) g = (m_last == 2) ? 1 : 2;
        else if (i_act) g = 1;
        else if (d_act) g = 2;
      end
      gc = (g == 1) ? ibus_req : dbus_req;
      exp_ib_wait = !(g == 1 && !mem_resp.waitrequest);
      exp_db_wait = !(g == 2 && !mem_resp.waitrequest);
      exp_ib_rdv  = !rst && m_out == 1 && mem_resp.readdatavalid;
      exp_db_rdv  = !rst && m_out == 2 && mem_resp.readdatavalid;
      if (g != 0) check("rand_mem_cmd", mem_req, gc);
      else check("rand_mem_rw_idle", {mem_req.read, mem_req.write}, 2'b00);
      check("rand_ibus_wait", ibus_resp.waitrequest, exp_ib_wait);
      check("rand_dbus_wait", dbus_resp.waitrequest, exp_db_wait);
      check("rand_ibus_rdv", ibus_resp.readdatavalid, exp_ib_rdv);
      check("rand_dbus_rdv", dbus_resp.readdatavalid, exp_db_rdv);
      check("rand_ibus_data", ibus_resp.readdata, mem_resp.readdata);
      check("rand_dbus_data", dbus_resp.readdata, mem_resp.readdata);
      if (rst) begin
        m_out = 0; m_stall = 0; m_last = 2;
      end else if (m_out != 0) begin
        if (mem_resp.readdatavalid) m_out = 0;
      end else if (g != 0) begin
        if (mem_resp.waitrequest) m_stall = g;
        else begin
          m_stall = 0;
          m_last  = g;
          if (gc.read) begin
            m_out  = g;
            rd_cnt = $urandom_range(1, 3);
          end
        end
      end
      if (!i_act || !exp_ib_wait) ib_next = rand_cmd();
      if (!d_act || !exp_db_wait) db_next = rand_cmd();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
